lcd_pixel_unpack: RTL and testbench
===================================

# lcd_pixel_unpack

Downstream consumer of the LCD controller's 256x32 pixel word buffer. Reads 32-bit words through the buffer's asynchronous read port and unpacks each word into pixels at 1, 2, 4, 8, 16 or 32 bpp. Delivers one pixel per cycle to the LCD timing/serializer stage over a valid/ready handshake. Returns its read pointer to the upstream buffer filler for full/empty bookkeeping.

## Interface
- No parameters. Buffer depth is fixed at 256 words.
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous and active-low
- flush  in  1  synchronous clear of the pointer and the held word; priority below rst_n and above all other inputs
- bpp_sel  in  3  0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp, 4=16bpp, 5/6/7=32bpp; sampled only at word load
- wr_ptr  in  9  filler's write pointer (wrap bit + 8-bit address); same clock domain
- rd_ptr  out  9  read pointer (wrap bit + address)
- raddr  out  8  buffer read address; always equals rd_ptr[7:0]
- rdata  in  32  buffer read data; combinational from raddr and valid within the same cycle
- pix_valid  out  1  pix_data holds a pixel
- pix_ready  in  1  the downstream stage accepts the pixel
- pix_data  out  24  pixel: LUT index or 16-bit value zero-extended; 32bpp carries word[23:0]
- underrun  out  1  registered one-cycle pulse for each starved request

## Operation
- State: word_q[31:0], word_vld, pix_idx[4:0], bpp_q[2:0], rd_ptr[8:0], underrun.
- Buffer empty when rd_ptr == wr_ptr. The buffer holds at most 256 unread words; keeping the filler within that limit is the filler's responsibility.
- Pixels per word (ppw): 32/16/8/4/2/1 for bpp 1/2/4/8/16/32.
- Pixel order is LSB-first: pixel k is bits [k*bpp + bpp-1 : k*bpp] of word_q.
- pix_valid = word_vld.
- pix_data is the field selected by pix_idx and bpp_q, zero-extended. It is combinational from registers only.
- consume = pix_valid & pix_ready.
- last = consume & (pix_idx == ppw(bpp_q) - 1).
- load = (~word_vld | last) & ~empty. On load:
  - word_q <= rdata
  - bpp_q <= bpp_sel
  - pix_idx <= 0
  - word_vld <= 1
  - rd_ptr <= rd_ptr + 1, with a 9-bit wrap; raddr wraps 255 -> 0
- consume without last: pix_idx <= pix_idx + 1.
- last without load: word_vld <= 0.
- underrun <= pix_ready & ~pix_valid, evaluated every cycle.
- A bpp_sel change takes effect only at the next word boundary. Pixels remaining in the current word keep bpp_q.
- flush or reset: rd_ptr = 0, word_vld = 0, pix_idx = 0, word_q = 0, bpp_q = 0, underrun = 0. A pending load or consume in that cycle is discarded. The filler must clear wr_ptr on the same flush.

## Timing
- Reset values: pix_valid 0, pix_data 0, rd_ptr 0, raddr 0, underrun 0.
- Load latency: the buffer becomes non-empty in cycle N with word_vld = 0 -> pix_valid = 1 in cycle N+1.
- Throughput: one pixel per cycle sustained at every bpp, including 32bpp. The last pixel of a word is followed by the next word's first pixel with no bubble, provided the buffer is non-empty in the last-pixel cycle.
- Backpressure: while pix_valid & ~pix_ready, pix_data, pix_idx and rd_ptr hold. No read advances.
- rd_ptr advances by at most 1 per cycle, and only in a load cycle.
- underrun asserts one cycle after the starved cycle and deasserts the cycle after pix_valid or ~pix_ready.
- The flush effect is visible in the cycle after flush is asserted: pix_valid 0, rd_ptr 0.

## Test plan
- 8bpp basic: after reset, mem[0] = 0x44332211, wr_ptr = 1, bpp_sel = 3, pix_ready = 1.
  - Required: pix_valid rises 1 cycle later; pix_data = 0x11, 0x22, 0x33, 0x44 on consecutive cycles; rd_ptr = 1.
  - Then pix_valid = 0 and underrun pulses each following cycle.
- 1bpp: mem[0] = 0x00000005, bpp_sel = 0.
  - Required: 32 pixels 1, 0, 1, then 29 zeros; exactly one rd_ptr increment.
- 32bpp streaming and wrap: stream 258 words with ready held high; word i = i | 0xFF000000.
  - Required: pix_data = i & 0xFFFFFF every cycle with no bubble.
  - Required: rd_ptr passes 0x0FF -> 0x100; raddr wraps to 0; final rd_ptr = 0x102.
- Backpressure: 4bpp word 0x87654321; drop pix_ready for 3 cycles after pixel 2.
  - Required: pix_data holds 0x3 for all 3 cycles; the sequence resumes 3, 4, ... 8 with no loss or duplication.
- bpp change mid-word: 8bpp words 0xDDCCBBAA, 0x22221111; switch bpp_sel to 4 (16bpp) after 2 pixels.
  - Required: pixels 0xAA, 0xBB, 0xCC, 0xDD, then 0x1111, 0x2222.
- Flush and empty: flush while pix_idx = 5 of a 2bpp word with 10 words buffered.
  - Required: next cycle pix_valid = 0, rd_ptr = 0, underrun = 0.
  - With wr_ptr = 0 and pix_ready = 1: raddr stays 0 and underrun pulses every cycle.

Source files
------------

// File: rtl/lcd_pixel_unpack.sv
// LCD pixel unpacker: pulls 32-bit words from the pixel buffer and streams them
// out LSB-first as 1/2/4/8/16/32 bpp pixels, one per cycle, over valid/ready.

module lcd_pixel_unpack_field #(
  parameter int BPP = 8
) (
  input  logic [31:0]                   word,
  input  logic [$clog2(32/BPP)-1:0]     idx,
  output logic [23:0]                   field
);
  localparam int PPW = 32 / BPP;

  logic [PPW-1:0][BPP-1:0] lanes;

  assign lanes = word;
  assign field = 24'(lanes[idx]);
endmodule

module lcd_pixel_unpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [2:0]  bpp_sel,
  input  logic [8:0]  wr_ptr,
  output logic [8:0]  rd_ptr,
  output logic [7:0]  raddr,
  input  logic [31:0] rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_data,
  output logic        underrun
);
  logic [31:0]      word_q;
  logic             word_vld;
  logic [4:0]       pix_idx;
  logic [2:0]       bpp_q;
  logic [4:0]       ppw_m1;
  logic             empty, consume, last, load;
  logic [5:0][23:0] fields;

  // One field extractor per sub-word depth; 32bpp needs no selection.
  for (genvar g = 0; g < 5; g++) begin : g_lane
    lcd_pixel_unpack_field #(.BPP(1 << g)) u_field (
      .word  (word_q),
      .idx   (pix_idx[$clog2(32 >> g)-1:0]),
      .field (fields[g])
    );
  end
  assign fields[5] = word_q[23:0];

  always_comb begin
    ppw_m1   = 5'd0;
    pix_data = fields[5];
    case (bpp_q)
      3'd0: begin ppw_m1 = 5'd31; pix_data = fields[0]; end
      3'd1: begin ppw_m1 = 5'd15; pix_data = fields[1]; end
      3'd2: begin ppw_m1 = 5'd7;  pix_data = fields[2]; end
      3'd3: begin ppw_m1 = 5'd3;  pix_data = fields[3]; end
      3'd4: begin ppw_m1 = 5'd1;  pix_data = fields[4]; end
      default: ;
    endcase
  end

  assign empty     = (rd_ptr == wr_ptr);
  assign pix_valid = word_vld;
  assign raddr     = rd_ptr[7:0];
  assign consume   = word_vld & pix_ready;
  assign last      = consume & (pix_idx == ppw_m1);
  // Refill in the last-pixel cycle so back-to-back words have no bubble.
  assign load      = (~word_vld | last) & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      word_q   <= '0;
      word_vld <= 1'b0;
      pix_idx  <= '0;
      bpp_q    <= '0;
      rd_ptr   <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= pix_ready & ~word_vld;
      if (load) begin
        word_q   <= rdata;
        bpp_q    <= bpp_sel;
        pix_idx  <= '0;
        word_vld <= 1'b1;
        rd_ptr   <= rd_ptr + 9'd1;
      end else if (last) begin
        word_vld <= 1'b0;
      end else if (consume) begin
        pix_idx  <= pix_idx + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_lcd_pixel_unpack.sv
// Scoreboard bench for lcd_pixel_unpack: expected pixels are queued as words
// are offered and popped whenever the DUT completes a pixel handshake.

module tb_lcd_pixel_unpack;
  logic        clk = 1'b0;
  logic        rst_n, flush, pix_ready;
  logic [2:0]  bpp_sel;
  logic [8:0]  wr_ptr, rd_ptr;
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic        pix_valid, underrun;
  logic [23:0] pix_data;

  logic [31:0] mem [256];
  logic [23:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  assign rdata = mem[raddr];

  lcd_pixel_unpack dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bpp_sel(bpp_sel),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .raddr(raddr), .rdata(rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] exp_pix(input logic [31:0] w, input int code, input int k);
    int b;
    logic [31:0] m;
    b = (code >= 5) ? 32 : (1 << code);
    m = (b == 32) ? 32'hFFFF_FFFF : ((32'd1 << b) - 32'd1);
    return 24'((w >> (k * b)) & m);
  endfunction

  task automatic push_word(input logic [31:0] w, input int code, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_pix(w, code, k));
  endtask

  task automatic do_reset;
    rst_n = 1'b0; flush = 1'b0; pix_ready = 1'b0; wr_ptr = '0; bpp_sel = '0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  // Scoreboard pop on every completed handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) chk("extra_pix", exp_q.size(), 1);
      else chk("pix", pix_data, exp_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // 8bpp basic, including reset values
    do_reset;
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_underrun", underrun, 0);
    mem[0] = 32'h4433_2211; bpp_sel = 3'd3; wr_ptr = 9'd1; pix_ready = 1'b1;
    push_word(mem[0], 3, 4);
    chk("b8_valid_n", pix_valid, 0);
    tick;
    chk("b8_valid_n1", pix_valid, 1);
    chk("b8_first", pix_data, 24'h11);
    chk("b8_rd_ptr", rd_ptr, 1);
    repeat (4) tick;
    chk("b8_drained", pix_valid, 0);
    chk("b8_rd_ptr_end", rd_ptr, 1);
    chk("b8_underrun_0", underrun, 0);
    tick; chk("b8_underrun_1", underrun, 1);
    tick; chk("b8_underrun_2", underrun, 1);
    chk("b8_q_empty", exp_q.size(), 0);

    // 1bpp
    do_reset;
    mem[0] = 32'h0000_0005; bpp_sel = 3'd0; wr_ptr = 9'd1; pix_ready = 1'b1;
    push_word(mem[0], 0, 32);
    tick;
    chk("b1_rd_ptr", rd_ptr, 1);
    repeat (32) tick;
    chk("b1_drained", pix_valid, 0);
    chk("b1_rd_ptr_end", rd_ptr, 1);
    chk("b1_q_empty", exp_q.size(), 0);

    // 32bpp streaming across the pointer wrap
    do_reset;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) | 32'hFF00_0000;
    bpp_sel = 3'd5; wr_ptr = 9'h100; pix_ready = 1'b1;
    for (int i = 0; i < 258; i++) exp_q.push_back(24'(i));
    for (int k = 1; k <= 258; k++) begin
      tick;
      chk("b32_valid", pix_valid, 1);
      chk("b32_rd_ptr", rd_ptr, 32'(k));
      chk("b32_raddr", raddr, 32'(k & 8'hFF));
      if (k <= 2) begin
        mem[k-1] = 32'(255 + k) | 32'hFF00_0000;
        wr_ptr = wr_ptr + 9'd1;
      end
    end
    tick;
    chk("b32_drained", pix_valid, 0);
    chk("b32_rd_ptr_end", rd_ptr, 9'h102);
    chk("b32_q_empty", exp_q.size(), 0);

    // Backpressure on a 4bpp word
    do_reset;
    mem[0] = 32'h8765_4321; bpp_sel = 3'd2; wr_ptr = 9'd1; pix_ready = 1'b1;
    push_word(mem[0], 2, 8);
    tick; tick; tick;
    pix_ready = 1'b0;
    repeat (3) begin
      chk("bp_hold_data", pix_data, 24'h3);
      chk("bp_hold_valid", pix_valid, 1);
      chk("bp_hold_rd_ptr", rd_ptr, 1);
      tick;
    end
    pix_ready = 1'b1;
    repeat (6) tick;
    chk("bp_drained", pix_valid, 0);
    chk("bp_q_empty", exp_q.size(), 0);

    // bpp change mid-word takes effect at the next word
    do_reset;
    mem[0] = 32'hDDCC_BBAA; mem[1] = 32'h2222_1111;
    bpp_sel = 3'd3; wr_ptr = 9'd2; pix_ready = 1'b1;
    exp_q.push_back(24'hAA); exp_q.push_back(24'hBB);
    exp_q.push_back(24'hCC); exp_q.push_back(24'hDD);
    exp_q.push_back(24'h1111); exp_q.push_back(24'h2222);
    tick; tick; tick;
    bpp_sel = 3'd4;
    repeat (4) tick;
    chk("bc_drained", pix_valid, 0);
    chk("bc_rd_ptr", rd_ptr, 2);
    chk("bc_q_empty", exp_q.size(), 0);

    // Flush mid-word, then an empty buffer
    do_reset;
    for (int i = 0; i < 10; i++) mem[i] = 32'hE4E4_E4E4 ^ (32'(i) << 8);
    bpp_sel = 3'd1; wr_ptr = 9'd10; pix_ready = 1'b1;
    push_word(mem[0], 1, 5);
    tick;
    repeat (5) tick;
    chk("fl_pix5", pix_data, 32'(exp_pix(mem[0], 1, 5)));
    flush = 1'b1; pix_ready = 1'b0; wr_ptr = 9'd0;
    tick;
    flush = 1'b0; pix_ready = 1'b1;
    chk("fl_valid", pix_valid, 0);
    chk("fl_rd_ptr", rd_ptr, 0);
    chk("fl_underrun", underrun, 0);
    chk("fl_data", pix_data, 0);
    repeat (2) begin
      tick;
      chk("fl_empty_underrun", underrun, 1);
      chk("fl_empty_raddr", raddr, 0);
      chk("fl_empty_valid", pix_valid, 0);
    end
    chk("fl_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
